// File: rtl/param_dcache.sv
// rtl/param_dcache.sv - parametrised N-way set-associative write-back, write-allocate data cache
// True-LRU ages per set, invalid-way-first victims, halt-time flush followed by a hit-counter store.
module param_dcache #(
  parameter int          NSETS     = 8,
  parameter int          NWAYS     = 2,
  parameter int          WPB       = 2,
  parameter logic [31:0] HCTR_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);
  localparam int WOB = $clog2(WPB);
  localparam int IB  = $clog2(NSETS);
  localparam int AB  = $clog2(NWAYS);
  localparam int TB  = 30 - WOB - IB;
  localparam int LB  = AB + IB;

  typedef enum logic [2:0] {ACCESS, WB, FILL, FLUSH_SCAN, FLUSH_WB, HCTR, HALT} state_t;
  state_t state, next_state;

  logic          valid [NWAYS][NSETS];
  logic          dirty [NWAYS][NSETS];
  logic [TB-1:0] tags  [NWAYS][NSETS];
  logic [31:0]   data  [NWAYS][NSETS][WPB];
  logic [AB-1:0] age   [NSETS][NWAYS];

  logic [31:0]  hit_counter;
  logic [WOB-1:0] wcnt;
  logic [AB-1:0]  victim;
  logic [LB:0]    fptr;

  logic [TB-1:0]  req_tag;
  logic [IB-1:0]  req_idx;
  logic [WOB-1:0] req_woff;
  logic [AB-1:0]  fway;
  logic [IB-1:0]  fset;
  logic           flush_done;
  logic           req_active;
  logic           last_word;
  logic           hit;
  logic [AB-1:0]  hit_way;
  logic [AB-1:0]  miss_victim;
  logic           lru_en;
  logic [AB-1:0]  lru_way;
  logic           unused_addr_bits;

  assign req_tag          = dmemaddr[31 -: TB];
  assign req_idx          = dmemaddr[2+WOB +: IB];
  assign req_woff         = dmemaddr[2 +: WOB];
  assign fway             = fptr[IB +: AB];
  assign fset             = fptr[IB-1:0];
  assign flush_done       = fptr[LB];
  assign req_active       = dmemREN | dmemWEN;
  assign last_word        = (wcnt == WOB'(WPB-1));
  assign unused_addr_bits = ^dmemaddr[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NWAYS-1; w >= 0; w--) begin
      if (valid[w][req_idx] && tags[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = AB'(w);
      end
    end
  end

  // Oldest way first, then overridden by the lowest-numbered invalid way if any.
  always_comb begin
    miss_victim = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (age[req_idx][w] == AB'(NWAYS-1)) miss_victim = AB'(w);
    end
    for (int w = NWAYS-1; w >= 0; w--) begin
      if (!valid[w][req_idx]) miss_victim = AB'(w);
    end
  end

  assign lru_en  = (state == ACCESS && !halt && req_active && hit) ||
                   (state == FILL && !dwait && last_word);
  assign lru_way = (state == FILL) ? victim : hit_way;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state <= ACCESS;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    dhit       = 1'b0;
    dmemload   = '0;
    flushed    = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    case (state)
      ACCESS: begin
        if (halt) begin
          next_state = FLUSH_SCAN;
        end else if (req_active) begin
          if (hit) begin
            dhit = 1'b1;
            if (dmemREN) dmemload = data[hit_way][req_idx][req_woff];
          end else if (valid[miss_victim][req_idx] && dirty[miss_victim][req_idx]) begin
            next_state = WB;
          end else begin
            next_state = FILL;
          end
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {tags[victim][req_idx], req_idx, wcnt, 2'b00};
        dstore = data[victim][req_idx][wcnt];
        if (!dwait && last_word) next_state = FILL;
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, wcnt, 2'b00};
        if (!dwait && last_word) next_state = ACCESS;
      end
      FLUSH_SCAN: begin
        if (flush_done) next_state = HCTR;
        else if (valid[fway][fset] && dirty[fway][fset]) next_state = FLUSH_WB;
      end
      FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = {tags[fway][fset], fset, wcnt, 2'b00};
        dstore = data[fway][fset][wcnt];
        if (!dwait && last_word) next_state = FLUSH_SCAN;
      end
      HCTR: begin
        dWEN   = 1'b1;
        daddr  = HCTR_ADDR;
        dstore = hit_counter;
        if (!dwait) next_state = HALT;
      end
      HALT: flushed = 1'b1;
      default: next_state = ACCESS;
    endcase
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      for (int w = 0; w < NWAYS; w++) begin
        for (int s = 0; s < NSETS; s++) begin
          valid[w][s] <= 1'b0;
          dirty[w][s] <= 1'b0;
          tags[w][s]  <= '0;
          age[s][w]   <= AB'(w);
          for (int k = 0; k < WPB; k++) data[w][s][k] <= '0;
        end
      end
      hit_counter <= '0;
      wcnt        <= '0;
      victim      <= '0;
      fptr        <= '0;
    end else begin
      if (lru_en) begin
        for (int w = 0; w < NWAYS; w++) begin
          if (AB'(w) == lru_way) age[req_idx][w] <= '0;
          else if (age[req_idx][w] < age[req_idx][lru_way]) age[req_idx][w] <= age[req_idx][w] + 1'b1;
        end
      end
      case (state)
        ACCESS: begin
          if (halt) begin
            fptr <= '0;
          end else if (req_active) begin
            if (hit) begin
              hit_counter <= hit_counter + 32'd1;
              if (dmemWEN && !dmemREN) begin
                data[hit_way][req_idx][req_woff] <= dmemstore;
                dirty[hit_way][req_idx]          <= 1'b1;
              end
            end else begin
              hit_counter <= hit_counter - 32'd1;
              victim      <= miss_victim;
              wcnt        <= '0;
              // The line is about to be overwritten word by word; drop it first.
              if (!(valid[miss_victim][req_idx] && dirty[miss_victim][req_idx]))
                valid[miss_victim][req_idx] <= 1'b0;
            end
          end
        end
        WB: begin
          if (!dwait) begin
            wcnt <= wcnt + 1'b1;
            if (last_word) begin
              dirty[victim][req_idx] <= 1'b0;
              valid[victim][req_idx] <= 1'b0;
              wcnt                   <= '0;
            end
          end
        end
        FILL: begin
          if (!dwait) begin
            data[victim][req_idx][wcnt] <= dload;
            wcnt <= wcnt + 1'b1;
            if (last_word) begin
              valid[victim][req_idx] <= 1'b1;
              dirty[victim][req_idx] <= 1'b0;
              tags[victim][req_idx]  <= req_tag;
            end
          end
        end
        FLUSH_SCAN: begin
          if (!flush_done) begin
            if (valid[fway][fset] && dirty[fway][fset]) wcnt <= '0;
            else fptr <= fptr + 1'b1;
          end
        end
        FLUSH_WB: begin
          if (!dwait) begin
            wcnt <= wcnt + 1'b1;
            if (last_word) begin
              dirty[fway][fset] <= 1'b0;
              fptr              <= fptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_param_dcache.sv
// tb/tb_param_dcache.sv - scoreboard bench for param_dcache against a line-level cache model
`timescale 1ns/1ps
module tb_param_dcache;
  localparam int NSETS = 8;
  localparam int NWAYS = 2;
  localparam int WPB   = 2;
  localparam logic [31:0] HCTR_ADDR = 32'h3100;
  localparam int LINE_BYTES = WPB * 4;

  logic CLK = 1'b0, nRST = 1'b0;
  logic dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;
  logic [31:0] dload = '0;
  logic dwait = 1'b0;

  param_dcache #(.NSETS(NSETS), .NWAYS(NWAYS), .WPB(WPB), .HCTR_ADDR(HCTR_ADDR)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct packed { logic rd; logic [31:0] data; } resp_t;
  bus_t  exp_bus[$];
  resp_t exp_resp[$];

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit m_valid [NWAYS][NSETS];
  bit m_dirty [NWAYS][NSETS];
  int m_tag   [NWAYS][NSETS];
  int m_stamp [NWAYS][NSETS];
  int m_time;
  int m_hctr;

  int rnd_pct = 0;
  bit stall_mode = 0, force_wait = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus_t b;
    b.we = we; b.addr = a; b.data = d;
    exp_bus.push_back(b);
  endtask

  task automatic model_reset();
    for (int w = 0; w < NWAYS; w++)
      for (int s = 0; s < NSETS; s++) begin
        m_valid[w][s] = 0; m_dirty[w][s] = 0; m_tag[w][s] = 0; m_stamp[w][s] = 0;
      end
    m_time = 0; m_hctr = 0;
    exp_bus.delete(); exp_resp.delete();
    ref_mem = mem;
  endtask

  // Cache is transparent: reads see the architectural memory; misses predict the bus traffic.
  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd, output bit hit);
    int idx, tag, w, vw;
    logic [31:0] base;
    resp_t r;
    idx = int'((a / LINE_BYTES) % NSETS);
    tag = int'(a / (LINE_BYTES * NSETS));
    w = -1;
    for (int i = 0; i < NWAYS; i++) if (m_valid[i][idx] && m_tag[i][idx] == tag) w = i;
    hit = (w >= 0);
    if (!hit) begin
      m_hctr--;
      vw = -1;
      for (int i = NWAYS-1; i >= 0; i--) if (!m_valid[i][idx]) vw = i;
      if (vw < 0) begin
        vw = 0;
        for (int i = 1; i < NWAYS; i++) if (m_stamp[i][idx] < m_stamp[vw][idx]) vw = i;
      end
      if (m_valid[vw][idx] && m_dirty[vw][idx]) begin
        base = 32'((m_tag[vw][idx] * NSETS + idx) * LINE_BYTES);
        for (int k = 0; k < WPB; k++) push_bus(1'b1, base + 32'(4*k), ref_rd(base + 32'(4*k)));
      end
      base = (a / LINE_BYTES) * LINE_BYTES;
      for (int k = 0; k < WPB; k++) push_bus(1'b0, base + 32'(4*k), 32'h0);
      m_valid[vw][idx] = 1; m_dirty[vw][idx] = 0; m_tag[vw][idx] = tag;
      w = vw;
    end
    m_hctr++;
    m_time++;
    m_stamp[w][idx] = m_time;
    if (wr) begin
      ref_mem[a] = wd;
      m_dirty[w][idx] = 1;
      r.rd = 1'b0; r.data = 32'h0;
    end else begin
      r.rd = 1'b1; r.data = ref_rd(a);
    end
    exp_resp.push_back(r);
  endtask

  task automatic model_halt();
    logic [31:0] base;
    for (int w = 0; w < NWAYS; w++)
      for (int s = 0; s < NSETS; s++)
        if (m_valid[w][s] && m_dirty[w][s]) begin
          base = 32'((m_tag[w][s] * NSETS + s) * LINE_BYTES);
          for (int k = 0; k < WPB; k++) push_bus(1'b1, base + 32'(4*k), ref_rd(base + 32'(4*k)));
          m_dirty[w][s] = 0;
        end
    push_bus(1'b1, HCTR_ADDR, 32'(m_hctr));
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    bit hit;
    int cyc;
    model_access(wr && !rd, a, wd, hit);
    dmemREN = rd; dmemWEN = wr; dmemaddr = a; dmemstore = wd;
    cyc = 0;
    while (1) begin
      @(negedge CLK);
      if (dhit) break;
      cyc++;
      if (cyc > 300) break;
    end
    total++;
    if (cyc > 300) begin
      bad++; $display("FAIL req_timeout addr=%h waited=%0d required dhit", a, cyc);
    end else if ((cyc == 0) != hit) begin
      bad++; $display("FAIL hit_latency addr=%h wait_cycles=%0d required_hit=%0d", a, cyc, hit);
    end
    @(posedge CLK); #1;
    dmemREN = 0; dmemWEN = 0;
  endtask

  task automatic reset_dut();
    nRST = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    model_reset();
    nRST = 1;
    @(posedge CLK); #1;
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_bus.size() != 0 || exp_resp.size() != 0) begin
      bad++; $display("FAIL %s pending_bus=%0d pending_resp=%0d required 0/0", name, exp_bus.size(), exp_resp.size());
    end
  endtask

  // Memory responder plus bus scoreboard; writes commit at the edge that completes them.
  bit pend = 0;
  logic [31:0] pend_a, pend_d;
  bit prev_wait = 0, prev_ren = 0, prev_wen = 0;
  logic [31:0] prev_addr = '0;
  int scnt = 0;
  always @(negedge CLK) begin
    bus_t b;
    pend = 0;
    if (!nRST) begin
      dwait = 0; dload = '0; scnt = 0; prev_wait = 0;
    end else begin
      if (dREN || dWEN) begin
        if (force_wait) dwait = 1;
        else if (stall_mode) begin
          if (scnt < 3) begin dwait = 1; scnt++; end
          else begin dwait = 0; scnt = 0; end
        end else dwait = ($urandom_range(0, 99) < rnd_pct);
        dload = dREN ? mem_rd(daddr) : 32'h0;
      end else begin
        dwait = 0; dload = '0; scnt = 0;
      end
      if (prev_wait) begin
        total++;
        if (daddr !== prev_addr || dREN !== prev_ren || dWEN !== prev_wen) begin
          bad++;
          $display("FAIL stall_hold addr=%h ren=%b wen=%b required addr=%h ren=%b wen=%b",
                   daddr, dREN, dWEN, prev_addr, prev_ren, prev_wen);
        end
      end
      prev_wait = (dREN || dWEN) && dwait;
      prev_addr = daddr; prev_ren = dREN; prev_wen = dWEN;
      if ((dREN || dWEN) && !dwait) begin
        if (dWEN) begin pend = 1; pend_a = daddr; pend_d = dstore; end
        total++;
        if (exp_bus.size() == 0) begin
          bad++; $display("FAIL unexpected_bus we=%b addr=%h data=%h required none", dWEN, daddr, dstore);
        end else begin
          b = exp_bus.pop_front();
          if (b.we !== dWEN || b.addr !== daddr || (b.we && b.data !== dstore)) begin
            bad++;
            $display("FAIL bus_xfer we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                     dWEN, daddr, dstore, b.we, b.addr, b.data);
          end
        end
      end
    end
  end

  always @(posedge CLK) if (pend && nRST) mem[pend_a] = pend_d;

  always @(negedge CLK) begin
    resp_t r;
    if (nRST && dhit) begin
      total++;
      if (exp_resp.size() == 0) begin
        bad++; $display("FAIL unexpected_dhit addr=%h load=%h required no dhit", dmemaddr, dmemload);
      end else begin
        r = exp_resp.pop_front();
        if (r.rd && dmemload !== r.data) begin
          bad++; $display("FAIL read_data addr=%h got=%h required=%h", dmemaddr, dmemload, r.data);
        end
      end
    end
  end

  initial begin
    int n, k, t, s, wo;
    logic [31:0] a;
    mem[32'h40] = 32'h11;
    mem[32'h44] = 32'h22;
    model_reset();
    nRST = 0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({dhit, dREN, dWEN, flushed} !== 4'b0 || daddr !== 0 || dstore !== 0 || dmemload !== 0) begin
      bad++;
      $display("FAIL reset_outputs hit=%b ren=%b wen=%b fl=%b addr=%h st=%h ld=%h required all 0",
               dhit, dREN, dWEN, flushed, daddr, dstore, dmemload);
    end
    nRST = 1;
    @(posedge CLK); #1;

    // first fill, then hits and read-over-write priority
    do_req(1, 0, 32'h40, 0);
    do_req(1, 0, 32'h44, 0);
    do_req(1, 1, 32'h44, 32'hBAD);
    do_req(1, 0, 32'h44, 0);

    // dirty line evicted by conflict fills in set 0
    do_req(0, 1, 32'h44, 32'hDEAD);
    do_req(1, 0, 32'h80, 0);
    do_req(1, 0, 32'hC0, 0);
    do_req(1, 0, 32'h100, 0);
    do_req(1, 0, 32'h44, 0);

    // LRU order in set 1
    do_req(1, 0, 32'h08, 0);
    do_req(1, 0, 32'h48, 0);
    do_req(1, 0, 32'h08, 0);
    do_req(1, 0, 32'h88, 0);
    do_req(1, 0, 32'h08, 0);

    // 3-cycle wait per word
    stall_mode = 1;
    do_req(1, 0, 32'h110, 0);
    do_req(0, 1, 32'h154, 32'h1234_5678);
    do_req(1, 0, 32'h114, 0);
    stall_mode = 0;

    rnd_pct = 30;
    for (n = 0; n < 150; n++) begin
      t = $urandom_range(0, 4); s = $urandom_range(0, NSETS-1); wo = $urandom_range(0, WPB-1);
      a = 32'(((t * NSETS + s) * WPB + wo) * 4);
      k = $urandom_range(0, 9);
      if (k < 5)      do_req(1, 0, a, 0);
      else if (k < 9) do_req(0, 1, a, $urandom);
      else            do_req(1, 1, a, $urandom);
    end
    rnd_pct = 0;
    @(posedge CLK); #1;
    check_drained("random_drain");

    // flush order and hit-counter store
    reset_dut();
    do_req(0, 1, 32'h18, 32'hA1);
    do_req(1, 0, 32'h18, 0);
    do_req(1, 0, 32'h28, 0);
    do_req(0, 1, 32'h68, 32'hB2);
    do_req(1, 0, 32'h1C, 0);
    do_req(1, 0, 32'h6C, 0);
    rnd_pct = 40;
    model_halt();
    halt = 1;
    @(posedge CLK); #1;
    halt = 0;
    n = 0;
    while (!flushed && n < 500) begin @(negedge CLK); n++; end
    total++;
    if (!flushed) begin bad++; $display("FAIL flush_timeout flushed=%b required 1", flushed); end
    check_drained("flush_drain");
    rnd_pct = 0;
    dmemREN = 1; dmemaddr = 32'h18;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      total++;
      if (flushed !== 1'b1 || dhit !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0) begin
        bad++; $display("FAIL halt_hold flushed=%b dhit=%b ren=%b wen=%b required 1 0 0 0", flushed, dhit, dREN, dWEN);
      end
    end
    @(posedge CLK); #1;
    dmemREN = 0;

    // reset in the middle of a writeback
    reset_dut();
    do_req(0, 1, 32'h200, 32'hC3);
    do_req(1, 0, 32'h240, 0);
    force_wait = 1;
    dmemREN = 1; dmemaddr = 32'h280;
    n = 0;
    while (n < 20) begin @(negedge CLK); if (dWEN) break; n++; end
    total++;
    if (dWEN !== 1'b1 || daddr !== 32'h200) begin
      bad++; $display("FAIL wb_start wen=%b addr=%h required 1 00000200", dWEN, daddr);
    end
    @(posedge CLK); #2;
    nRST = 0;
    #1;
    total++;
    if ({dhit, dREN, dWEN, flushed} !== 4'b0 || daddr !== 0 || dstore !== 0 || dmemload !== 0) begin
      bad++;
      $display("FAIL midwb_reset hit=%b ren=%b wen=%b fl=%b addr=%h st=%h ld=%h required all 0",
               dhit, dREN, dWEN, flushed, daddr, dstore, dmemload);
    end
    @(posedge CLK); #1;
    dmemREN = 0;
    force_wait = 0;
    model_reset();
    nRST = 1;
    @(posedge CLK); #1;
    do_req(1, 0, 32'h200, 0);
    @(posedge CLK); #1;
    check_drained("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
